clk_sel_ctrl: RTL and testbench
===============================

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 8: clk cycles held in SWITCH after select changes; legal range 4..255.
REQ-002 Parameter HOLD_CYC, default 16: minimum clk cycles in HOLD before the next switch may start; legal range 1..255.
REQ-003 Parameter RST_SEL, default 0: select value while in reset.
REQ-004 clk  input  1: always-on reference clock; all logic on posedge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 sw_req  input  1: one-cycle switch request pulse.
REQ-007 sw_target  input  1: requested source (0 = clk0, 1 = clk1), sampled with sw_req.
REQ-008 clk0_ok, clk1_ok  input  1 each: source-present flags, already synchronous to clk.
REQ-009 select  output  1: registered drive to the glitch-free clock mux (1 = clk1).
REQ-010 busy  output  1: high in SWITCH and HOLD.
REQ-011 done  output  1: one-cycle pulse when a switch completes or a no-op request is accepted.
REQ-012 err  output  1: one-cycle pulse on a rejected request.
REQ-013 auto_sw  output  1: one-cycle pulse when an automatic failover starts.

Function
REQ-014 FSM states: IDLE, SWITCH, HOLD.
REQ-015 IDLE with sw_req=1 and sw_target != select and target ok=1: next cycle select <= sw_target, settle counter <= 0, state <= SWITCH.
REQ-016 IDLE with sw_req=1 and sw_target == select: no select change; done pulses next cycle; state stays IDLE.
REQ-017 IDLE with sw_req=1 and target ok=0: err pulses next cycle; select unchanged.
REQ-018 sw_req while busy=1: ignored; err pulses next cycle.
REQ-019 Failover: IDLE, no sw_req, current source ok=0, other source ok=1: select flips, auto_sw pulses, state <= SWITCH.
REQ-020 sw_req and a failover condition in the same IDLE cycle: the request takes priority; failover is re-evaluated on return to IDLE.
REQ-021 Both ok=0 in IDLE: no switch and no pulse; select holds.
REQ-022 SWITCH: counter increments each cycle; at count SETTLE_CYC-1, done pulses, counter clears, state <= HOLD.
REQ-023 HOLD: counter increments; at HOLD_CYC-1, state <= IDLE.
REQ-024 ok inputs are ignored during SWITCH and HOLD; select never changes outside the IDLE-to-SWITCH transition.
REQ-025 Latency: sw_req accepted in cycle N gives a select change at N+1 and done at N+1+SETTLE_CYC.
REQ-026 Counter width is 8 bits; the counter never wraps because it clears on each state change.
REQ-027 done, err, and auto_sw are mutually exclusive in any cycle.

Reset
REQ-028 rst=1 forces state=IDLE, counter=0, select=RST_SEL, busy=0, done=0, err=0, auto_sw=0, immediately and asynchronously.
REQ-029 Reset asserted mid-SWITCH or mid-HOLD aborts the operation with no done pulse; the first post-reset cycle is IDLE.

Structure
REQ-030 State encoding (IDLE/SWITCH/HOLD) and the 8-bit counter width constant reside in the shared clock-control package.
REQ-031 Single flat module with no sub-modules; all outputs are registered.

Verification
REQ-032 Reset release, clk0_ok=1, clk1_ok=1, sw_req with target 1: select=1 one cycle later, done 9 cycles after the request (SETTLE_CYC=8), busy low 25 cycles after the request.
REQ-033 select=0, sw_req with target 1, clk1_ok=0: err pulse, select stays 0, busy stays 0.
REQ-034 select=1, clk1_ok drops, clk0_ok=1: auto_sw pulse and select=0 on the next cycle; a second drop during HOLD is ignored.
REQ-035 sw_req issued during HOLD: err pulse; no select change until IDLE.
REQ-036 rst asserted 3 cycles into SWITCH with select=1 and RST_SEL=0: select=0 immediately, no done pulse.
REQ-037 sw_req with target equal to select: done pulse next cycle, busy never rises.

Source files
------------

// File: rtl/clk_sel_ctrl_pkg.sv
// Shared definitions for the clock-select controller.
//   state_t : FSM encoding (IDLE / SWITCH / HOLD)
//   CNT_W   : width of the settle/hold counter
package clk_sel_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/clk_sel_ctrl.sv
// Clock-select controller for a glitch-free two-input clock mux.
// Accepts software switch requests, performs automatic failover when the
// current source disappears, and enforces a settle period after each
// select change followed by a hold-off period before the next switch.
//
// Parameters:
//   SETTLE_CYC (4..255) clk cycles spent in SWITCH after select changes
//   HOLD_CYC   (1..255) clk cycles spent in HOLD before returning to IDLE
//   RST_SEL             select value while in reset
// Ports:
//   clk, rst            reference clock, async active-high reset
//   sw_req, sw_target   one-cycle request pulse and requested source
//   clk0_ok, clk1_ok    source-present flags (synchronous to clk)
//   select              registered mux select (1 = clk1)
//   busy                high in SWITCH and HOLD
//   done, err, auto_sw  mutually exclusive one-cycle status pulses
module clk_sel_ctrl
  import clk_sel_ctrl_pkg::*;
#(
  parameter int   SETTLE_CYC = 8,
  parameter int   HOLD_CYC   = 16,
  parameter logic RST_SEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_req,
  input  logic sw_target,
  input  logic clk0_ok,
  input  logic clk1_ok,
  output logic select,
  output logic busy,
  output logic done,
  output logic err,
  output logic auto_sw
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic tgt_ok, cur_ok, oth_ok;

  assign tgt_ok = sw_target ? clk1_ok : clk0_ok;
  assign cur_ok = select    ? clk1_ok : clk0_ok;
  assign oth_ok = select    ? clk0_ok : clk1_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      select  <= RST_SEL;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      auto_sw <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      auto_sw <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A request always wins over failover; failover is re-checked
          // on the next IDLE cycle.
          if (sw_req) begin
            if (sw_target == select) begin
              done <= 1'b1;
            end else if (tgt_ok) begin
              select <= sw_target;
              cnt    <= '0;
              state  <= ST_SWITCH;
              busy   <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (!cur_ok && oth_ok) begin
            select  <= ~select;
            auto_sw <= 1'b1;
            cnt     <= '0;
            state   <= ST_SWITCH;
            busy    <= 1'b1;
          end
        end
        ST_SWITCH: begin
          if (cnt == SETTLE_LAST) begin
            // Completion pulse takes the slot; a request landing in this
            // same cycle is dropped without err to keep pulses exclusive.
            done  <= 1'b1;
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            if (sw_req) err <= 1'b1;
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (sw_req) err <= 1'b1;
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl (default parameters: SETTLE 8, HOLD 16,
// RST_SEL 0). Outputs are compared as {select, busy, done, err, auto_sw}.
module tb_clk_sel_ctrl;

  logic clk = 1'b0;
  logic rst, sw_req, sw_target, clk0_ok, clk1_ok;
  logic select, busy, done, err, auto_sw;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_sel_ctrl #(.SETTLE_CYC(8), .HOLD_CYC(16), .RST_SEL(1'b0)) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_target(sw_target),
    .clk0_ok(clk0_ok), .clk1_ok(clk1_ok), .select(select), .busy(busy),
    .done(done), .err(err), .auto_sw(auto_sw)
  );

  typedef struct {
    string      name;
    logic       req, tgt, c0, c1;
    logic [4:0] exp;  // {select, busy, done, err, auto_sw}
  } vec_t;

  function automatic logic [4:0] outs();
    return {select, busy, done, err, auto_sw};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sel,busy,done,err,auto}=%b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic req, input logic tgt, input logic c0, input logic c1);
    @(negedge clk);
    sw_req = req; sw_target = tgt; clk0_ok = c0; clk1_ok = c1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"idle_quiet",        1'b0, 1'b0, 1'b1, 1'b1, 5'b00000};
    vecs[1] = '{"noop_req_done",     1'b1, 1'b0, 1'b1, 1'b1, 5'b00100};
    vecs[2] = '{"noop_busy_low",     1'b0, 1'b0, 1'b1, 1'b1, 5'b00000};
    vecs[3] = '{"req_tgt_bad_err",   1'b1, 1'b1, 1'b1, 1'b0, 5'b00010};
    vecs[4] = '{"other_bad_no_fo",   1'b0, 1'b0, 1'b1, 1'b0, 5'b00000};
    vecs[5] = '{"both_bad_hold",     1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[6] = '{"both_bad_req_err",  1'b1, 1'b1, 1'b0, 1'b0, 5'b00010};

    rst = 1'b1; sw_req = 1'b0; sw_target = 1'b0; clk0_ok = 1'b1; clk1_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", outs(), 5'b00000);
    @(negedge clk) rst = 1'b0;

    // Single-cycle IDLE behaviour
    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].tgt, vecs[i].c0, vecs[i].c1);
      chk(vecs[i].name, outs(), vecs[i].exp);
    end

    // Software switch 0->1; err-on-request during HOLD (i==12)
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sw_sel_next", outs(), 5'b11000);
    for (int i = 1; i <= 24; i++) begin
      step(i == 12, 1'b0, 1'b1, 1'b1);
      chk($sformatf("sw_seq_%0d", i), outs(),
          {1'b1, (i < 24), (i == 8), (i == 12), 1'b0});
    end

    // Failover 1->0; clk0 drops during HOLD (ignored), then failover back
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fo_start", outs(), 5'b01001);
    for (int i = 1; i <= 25; i++) begin
      if (i < 10) step(1'b0, 1'b0, 1'b1, 1'b0);
      else        step(1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("fo_seq_%0d", i), outs(),
          {(i == 25), (i < 24 || i == 25), (i == 8), 1'b0, (i == 25)});
    end

    // Reset 3 cycles into SWITCH with select=1: immediate, no done
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("pre_rst_%0d", i), outs(), 5'b11000);
    end
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_async", outs(), 5'b00000);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_hold_%0d", i), outs(), 5'b00000);
    end
    @(negedge clk) rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("post_rst_idle", outs(), 5'b00000);

    // Request and failover in the same cycle: request wins, failover next
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("req_beats_fo", outs(), 5'b00100);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fo_after_req", outs(), 5'b11001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
